// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin I-cache/D-cache arbiter for one main-memory port, one line burst per grant (optional ARB_PERF_EN perf counters)
module mem_burst_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_req,
  input  logic [31:0]      ic_addr,
  output logic             ic_gnt,
  output logic             ic_rvalid,
  input  logic             dc_req,
  input  logic             dc_we,
  input  logic [31:0]      dc_addr,
  input  logic [31:0]      dc_wdata,
  output logic [CNT_W-1:0] dc_widx,
  output logic             dc_gnt,
  output logic             dc_rvalid,
  output logic             ic_last,
  output logic             dc_last,
  output logic [31:0]      rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
`ifdef ARB_PERF_EN
  output logic [31:0]      perf_conflict_cnt,
  output logic [31:0]      perf_wait_cnt,
`endif
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic owner_q, owner_d, last_owner_q, last_owner_d, we_q, we_d;
  logic ic_gnt_q, ic_gnt_d, dc_gnt_q, dc_gnt_d;
  logic [31:0] base_q, base_d;
  logic burst, acc, last_word;
  assign burst     = state_q == BURST;
  assign acc       = burst & mem_ack;
  assign last_word = cnt_q == CNT_W'(LINE_WORDS - 1);
  assign busy      = state_q != IDLE;
  assign mem_req   = burst;
  assign mem_we    = burst & we_q;
  assign mem_addr  = burst ? base_q | (32'(cnt_q) << 2) : '0;
  assign mem_wdata = (burst & we_q) ? dc_wdata : '0;
  assign rdata     = burst ? mem_rdata : '0;
  assign dc_widx   = cnt_q;
  assign ic_rvalid = acc & ~we_q & ~owner_q;
  assign dc_rvalid = acc & ~we_q & owner_q;
  assign ic_last   = acc & last_word & ~owner_q;
  assign dc_last   = acc & last_word & owner_q;
  assign ic_gnt    = ic_gnt_q;
  assign dc_gnt    = dc_gnt_q;
  // next-state: arbitrate in IDLE (owner 1 = D-cache), step words in BURST, one dead cycle in DONE
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    base_d       = base_q;
    we_d         = we_q;
    ic_gnt_d     = 1'b0;
    dc_gnt_d     = 1'b0;
    case (state_q)
      IDLE: if (ic_req | dc_req) begin
        owner_d  = (ic_req & dc_req) ? ~last_owner_q : dc_req;
        base_d   = (owner_d ? dc_addr : ic_addr) & ~32'(LINE_WORDS * 4 - 1);
        we_d     = owner_d & dc_we;
        cnt_d    = '0;
        ic_gnt_d = ~owner_d;
        dc_gnt_d = owner_d;
        state_d  = BURST;
      end
      BURST: if (mem_ack) begin
        cnt_d = last_word ? '0 : cnt_q + 1'b1;
        if (last_word) begin
          last_owner_d = owner_q;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; last_owner resets to D-cache so the first tie goes to the I-cache
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      base_q       <= '0;
      we_q         <= 1'b0;
      ic_gnt_q     <= 1'b0;
      dc_gnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      base_q       <= base_d;
      we_q         <= we_d;
      ic_gnt_q     <= ic_gnt_d;
      dc_gnt_q     <= dc_gnt_d;
    end
  end
`ifdef ARB_PERF_EN
  logic [31:0] conf_q, conf_d, wait_q, wait_d;
  logic conf_inc, wait_inc;
  // saturating counters: IDLE ties, and cycles where the side not owning the port is requesting
  always_comb begin
    conf_inc = (state_q == IDLE) & ic_req & dc_req;
    wait_inc = (state_q == IDLE) ? conf_inc : (owner_q ? ic_req : dc_req);
    conf_d   = (conf_inc & ~&conf_q) ? conf_q + 32'd1 : conf_q;
    wait_d   = (wait_inc & ~&wait_q) ? wait_q + 32'd1 : wait_q;
  end
  // perf counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_q <= '0;
      wait_q <= '0;
    end else begin
      conf_q <= conf_d;
      wait_q <= wait_d;
    end
  end
  assign perf_conflict_cnt = conf_q;
  assign perf_wait_cnt     = wait_q;
`endif
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: directed and random bursts checked against a transaction-level model
module tb_mem_burst_arbiter;
  localparam int LW = 8;
  logic clk = 0, rst = 0;
  logic ic_req = 0, dc_req = 0, dc_we = 0, mem_ack = 0;
  logic [31:0] ic_addr = 0, dc_addr = 0, dc_wdata = 0, mem_rdata = 0;
  logic ic_gnt, ic_rvalid, dc_gnt, dc_rvalid, ic_last, dc_last, mem_req, mem_we, busy;
  logic [2:0] dc_widx;
  logic [31:0] rdata, mem_addr, mem_wdata;
  int tests = 0, fails = 0, cyc = 0, words = 0, ack_mode = 0;
  int ic_last_n = 0, dc_last_n = 0, dc_rv_n = 0, c0;
  bit act = 0, dead = 0, egi = 0, egd = 0, m_owner = 0, m_we = 0, last_owner = 1, drop_on_last = 1;
  logic [31:0] m_base = 0;
  int g_cyc[$];
  bit g_own[$];
  logic [31:0] addrs[$];

  mem_burst_arbiter #(.LINE_WORDS(LW), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_widx(dc_widx),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .ic_last(ic_last), .dc_last(dc_last), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive memory side, check outputs against the model, advance the model
  task automatic step();
    bit a, ev, rd, drop_ic, drop_dc;
    a = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? (cyc % 2 == 1) : ($urandom % 10 < 7);
    mem_ack = a;
    dc_wdata = $urandom;
    mem_rdata = dat(mem_addr);
    drop_ic = 0;
    drop_dc = 0;
    #1;
    chk("ic_gnt", 32'(ic_gnt), 32'(egi));
    chk("dc_gnt", 32'(dc_gnt), 32'(egd));
    if (egi | egd) begin
      g_cyc.push_back(cyc);
      g_own.push_back(egd);
    end
    chk("busy", 32'(busy), 32'(act | dead));
    chk("mem_req", 32'(mem_req), 32'(act));
    if (act) begin
      chk("mem_addr", mem_addr, m_base + 32'(4 * words));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_wdata", mem_wdata, dc_wdata);
        chk("dc_widx", 32'(dc_widx), 32'(words));
      end
    end
    ev = act && a;
    rd = ev && !m_we;
    chk("ic_rvalid", 32'(ic_rvalid), 32'(rd && !m_owner));
    chk("dc_rvalid", 32'(dc_rvalid), 32'(rd && m_owner));
    if (rd) chk("rdata", rdata, dat(m_base + 32'(4 * words)));
    chk("ic_last", 32'(ic_last), 32'(ev && words == LW - 1 && !m_owner));
    chk("dc_last", 32'(dc_last), 32'(ev && words == LW - 1 && m_owner));
    if (ic_last) ic_last_n++;
    if (dc_last) dc_last_n++;
    if (dc_rvalid) dc_rv_n++;
    if (ev) addrs.push_back(mem_addr);
    egi = 0;
    egd = 0;
    if (act) begin
      if (ev) begin
        words++;
        if (words == LW) begin
          act = 0;
          dead = 1;
          last_owner = m_owner;
          drop_ic = drop_on_last && !m_owner;
          drop_dc = drop_on_last && m_owner;
        end
      end
    end else if (dead) dead = 0;
    else if (ic_req || dc_req) begin
      m_owner = (ic_req && dc_req) ? !last_owner : dc_req;
      m_base = (m_owner ? dc_addr : ic_addr) & ~32'(LW * 4 - 1);
      m_we = m_owner && dc_we;
      words = 0;
      act = 1;
      egi = !m_owner;
      egd = m_owner;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (drop_ic) ic_req = 0;
    if (drop_dc) dc_req = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((act || dead || egi || egd || ic_req || dc_req) && n < max) begin
      step();
      n++;
    end
    tests++;
    assert (n < max) else begin
      fails++;
      $error("FAIL idle_timeout: waited %0d cycles, limit %0d", n, max);
    end
  endtask

  initial begin
    mem_ack = 1;
    mem_rdata = 32'hDEAD_BEEF;
    dc_wdata = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ic_gnt", 32'(ic_gnt), 0);
    chk("rst_dc_gnt", 32'(dc_gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_dc_widx", 32'(dc_widx), 0);
    chk("rst_ic_rvalid", 32'(ic_rvalid), 0);
    chk("rst_dc_last", 32'(dc_last), 0);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;
    // tie after reset: IC, DC, IC with 10-cycle spacing
    drop_on_last = 0;
    ic_addr = 32'h1000;
    dc_addr = 32'h2000;
    ic_req = 1;
    dc_req = 1;
    for (int i = 0; i < 60 && g_cyc.size() < 3; i++) step();
    ic_req = 0;
    dc_req = 0;
    drop_on_last = 1;
    wait_idle(40);
    chk("tie_grants", 32'(g_own.size()), 3);
    if (g_own.size() >= 3) begin
      chk("tie_own0", 32'(g_own[0]), 0);
      chk("tie_own1", 32'(g_own[1]), 1);
      chk("tie_own2", 32'(g_own[2]), 0);
      chk("tie_gap1", 32'(g_cyc[1] - g_cyc[0]), 10);
      chk("tie_gap2", 32'(g_cyc[2] - g_cyc[1]), 10);
    end
    // I-cache refill only
    g_cyc.delete();
    addrs.delete();
    ic_last_n = 0;
    ic_addr = 32'h1234;
    ic_req = 1;
    c0 = cyc;
    wait_idle(40);
    chk("ic_gnt_cycle", 32'(g_cyc.size() > 0 ? g_cyc[0] : -1), 32'(c0 + 1));
    chk("ic_words", 32'(addrs.size()), 8);
    if (addrs.size() == 8) begin
      chk("ic_addr_first", addrs[0], 32'h1220);
      chk("ic_addr_last", addrs[7], 32'h123C);
    end
    chk("ic_last_count", 32'(ic_last_n), 1);
    // D-cache writeback, ack every other cycle
    ack_mode = 1;
    dc_last_n = 0;
    dc_rv_n = 0;
    dc_we = 1;
    dc_addr = 32'h80;
    dc_req = 1;
    wait_idle(60);
    chk("wb_last_count", 32'(dc_last_n), 1);
    chk("wb_rvalid_count", 32'(dc_rv_n), 0);
    // D-cache drops its request at word 3
    ack_mode = 0;
    dc_we = 0;
    dc_addr = 32'h4444_0040;
    dc_req = 1;
    addrs.delete();
    dc_last_n = 0;
    for (int i = 0; i < 20 && !(act && words == 3); i++) step();
    dc_req = 0;
    wait_idle(30);
    chk("drop_words", 32'(addrs.size()), 8);
    chk("drop_last_count", 32'(dc_last_n), 1);
    // random traffic with random acks
    ack_mode = 2;
    for (int i = 0; i < 800; i++) begin
      if (!ic_req && $urandom % 6 == 0) begin
        ic_req = 1;
        ic_addr = $urandom;
      end
      if (!dc_req && $urandom % 6 == 0) begin
        dc_req = 1;
        dc_addr = $urandom;
        dc_we = 1'($urandom);
      end
      step();
    end
    ic_req = 0;
    dc_req = 0;
    wait_idle(60);
    // asynchronous reset at word 5 of an I-cache burst
    ack_mode = 0;
    ic_addr = 32'h300;
    ic_req = 1;
    for (int i = 0; i < 20 && !(act && words == 5 && !m_owner); i++) step();
    mem_ack = 1;
    #1;
    rst = 0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ic_rvalid", 32'(ic_rvalid), 0);
    chk("arst_ic_last", 32'(ic_last), 0);
    @(posedge clk);
    #2;
    rst = 1;
    ic_req = 0;
    act = 0;
    dead = 0;
    egi = 0;
    egd = 0;
    words = 0;
    last_owner = 1;
    @(posedge clk);
    #1;
    cyc++;
    g_own.delete();
    dc_addr = 32'h500;
    dc_req = 1;
    wait_idle(40);
    chk("post_rst_owner", 32'(g_own.size() > 0 ? g_own[0] : 1'b0), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
